// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: IF/ID bundle and the fetch request FSM states.
package rv32i_types;

  localparam logic [31:0] FETCH_RESET_PC = 32'h1eceb000;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
  } if_id_stage_reg_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } fetch_state_t;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_fifo.sv
// Two-entry FIFO between instruction memory and decode, with synchronous clear.
module fetch_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wptr_q, wptr_d;
  logic         rptr_q, rptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push_ok, pop_ok;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign count = cnt_q;
  assign rdata = mem_q[rptr_q];

  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  // Pointer/count update; clear wins over push and pop.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr) begin
      wptr_d = 1'b0;
      rptr_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      if (push_ok) begin
        mem_d[wptr_q] = wdata;
        wptr_d        = ~wptr_q;
      end
      if (pop_ok) rptr_d = ~rptr_q;
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Data storage needs no reset; empty entries are never presented as valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, issues one request at a time and
// buffers responses in a 2-entry FIFO presented to decode as IF/ID.
module fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  output logic [3:0]       imem_rmask,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_resp,
  input  logic             stall_signal,
  input  logic             freeze_stall,
  input  logic             flush_pipeline,
  input  logic [31:0]      redirect_pc,
  output if_id_stage_reg_t if_id,
  output logic [31:0]      imem_rdata_id,
  output logic             imem_resp_id
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [3:0]   rmask_q, rmask_d;

  logic         push, pop, advance;
  logic         fifo_full, fifo_empty;
  logic [1:0]   fifo_cnt, cnt_nxt;
  logic [63:0]  head;

  assign advance = ~fifo_empty & ~stall_signal & ~freeze_stall;
  assign pop     = advance & ~flush_pipeline;

  fetch_fifo #(.W(64)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush_pipeline),
    .push  (push),
    .pop   (pop),
    .wdata ({fetch_pc_q, imem_rdata}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign if_id.pc      = head[63:32];
  assign if_id.valid   = ~fifo_empty;
  assign imem_rdata_id = head[31:0];
  assign imem_resp_id  = ~fifo_empty;
  assign imem_addr     = addr_q;
  assign imem_rmask    = rmask_q;

  // Next-state: retire/drop the response, then re-issue straight from IDLE
  // whenever the FIFO will still have a free slot, so the request appears
  // the cycle after a response (or after a flush/reset).
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    rmask_d    = rmask_q;
    push       = 1'b0;
    if (flush_pipeline) fetch_pc_d = word_align(redirect_pc);
    case (state_q)
      WAIT: begin
        if (imem_resp) begin
          if (!flush_pipeline) begin
            push       = ~fifo_full | pop;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
          state_d = IDLE;
        end else if (flush_pipeline) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   if (imem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_pipeline) cnt_nxt = 2'd0;
    else begin
      case ({push, pop})
        2'b10:   cnt_nxt = fifo_cnt + 2'd1;
        2'b01:   cnt_nxt = fifo_cnt - 2'd1;
        default: cnt_nxt = fifo_cnt;
      endcase
    end
    if (state_d == IDLE) begin
      if (cnt_nxt != 2'd2) begin
        state_d = WAIT;
        addr_d  = fetch_pc_d;
        rmask_d = 4'hF;
      end else begin
        rmask_d = 4'h0;
      end
    end
  end

  // FSM and registered memory-request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      rmask_q    <= 4'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      rmask_q    <= rmask_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Cycle-table bench for fetch_stage with a configurable-latency memory model.
module tb_fetch_stage;
  import rv32i_types::*;

  localparam logic [31:0] B = 32'h1eceb000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      imem_addr;
  logic [3:0]       imem_rmask;
  logic [31:0]      imem_rdata = 32'h0;
  logic             imem_resp = 1'b0;
  logic             stall_signal = 1'b0;
  logic             freeze_stall = 1'b0;
  logic             flush_pipeline = 1'b0;
  logic [31:0]      redirect_pc = 32'h0;
  if_id_stage_reg_t if_id;
  logic [31:0]      imem_rdata_id;
  logic             imem_resp_id;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .stall_signal   (stall_signal),
    .freeze_stall   (freeze_stall),
    .flush_pipeline (flush_pipeline),
    .redirect_pc    (redirect_pc),
    .if_id          (if_id),
    .imem_rdata_id  (imem_rdata_id),
    .imem_resp_id   (imem_resp_id)
  );

  always #5 clk = ~clk;

  // Memory: answers a held request after mem_lat extra cycles; data = ~addr.
  int mem_lat = 1;
  int age = 0;
  always @(posedge clk) begin
    #2;
    if (rst || imem_rmask != 4'hF) begin
      age = 0;
      imem_resp = 1'b0;
    end else if (age == mem_lat) begin
      imem_resp  = 1'b1;
      imem_rdata = ~imem_addr;
      age = 0;
    end else begin
      imem_resp = 1'b0;
      age++;
    end
  end

  typedef struct {
    bit          chk;
    bit          rst;
    bit          stall;
    bit          frz;
    bit          flush;
    int          lat;
    logic [31:0] redir;
    bit          ev;
    logic [31:0] epc;
    bit          erm;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tv[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic add(input bit chk, input bit r, input bit st, input bit fz,
                     input bit fl, input logic [31:0] rd, input int lat,
                     input bit ev, input logic [31:0] epc,
                     input bit erm, input logic [31:0] eaddr);
    vec_t v;
    v.chk = chk; v.rst = r; v.stall = st; v.frz = fz; v.flush = fl;
    v.redir = rd; v.lat = lat; v.ev = ev; v.epc = epc; v.erm = erm; v.eaddr = eaddr;
    tv.push_back(v);
  endtask

  // Reset row: rst driven this cycle, outputs not checked.
  task automatic rr(input int lat);
    add(0, 1, 0, 0, 0, 32'h0, lat, 0, 32'h0, 0, 32'h0);
  endtask

  // Cycle row: check outputs, then drive stall/freeze/flush for this cycle.
  task automatic cy(input bit st, input bit fz, input bit fl, input logic [31:0] rd,
                    input int lat, input bit ev, input logic [31:0] epc,
                    input bit erm, input logic [31:0] eaddr);
    add(1, 0, st, fz, fl, rd, lat, ev, epc, erm, eaddr);
  endtask

  task automatic check(input int row, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL row %0d %s: got %h expected %h", row, nm, act, exp);
    end
  endtask

  initial begin
    // Straight-line fetch, latency 1, then a 6-cycle stall/freeze.
    rr(1);
    cy(0,0,0,0,1, 0,0,      0,0);
    cy(0,0,0,0,1, 0,0,      1,B);
    cy(0,0,0,0,1, 0,0,      1,B);
    cy(0,0,0,0,1, 1,B,      1,B+4);
    cy(0,0,0,0,1, 0,0,      1,B+4);
    cy(0,0,0,0,1, 1,B+4,    1,B+8);
    cy(0,0,0,0,1, 0,0,      1,B+8);
    cy(0,0,0,0,1, 1,B+8,    1,B+12);
    cy(1,0,0,0,1, 0,0,      1,B+12);
    cy(1,0,0,0,1, 1,B+12,   1,B+16);
    cy(1,0,0,0,1, 1,B+12,   1,B+16);
    cy(1,0,0,0,1, 1,B+12,   0,0);
    cy(0,1,0,0,1, 1,B+12,   0,0);
    cy(0,1,0,0,1, 1,B+12,   0,0);
    cy(0,0,0,0,1, 1,B+12,   0,0);
    cy(0,0,0,0,1, 1,B+16,   1,B+20);
    cy(0,0,0,0,1, 0,0,      1,B+20);
    cy(0,0,0,0,1, 1,B+20,   1,B+24);
    // Flush while WAIT (latency 2): misaligned redirect, in-flight word dropped.
    rr(2);
    cy(0,0,0,0,2,            0,0, 0,0);
    cy(0,0,1,32'h1eceb103,2, 0,0, 1,B);
    cy(0,0,0,0,2,            0,0, 1,B);
    cy(0,0,0,0,2,            0,0, 1,B);
    cy(0,0,0,0,2,            0,0, 1,B+32'h100);
    cy(0,0,0,0,2,            0,0, 1,B+32'h100);
    cy(0,0,0,0,2,            0,0, 1,B+32'h100);
    cy(0,0,0,0,2, 1,B+32'h100,    1,B+32'h104);
    // Flush on the response cycle with one entry buffered under stall.
    rr(1);
    cy(1,0,0,0,1,            0,0, 0,0);
    cy(1,0,0,0,1,            0,0, 1,B);
    cy(1,0,0,0,1,            0,0, 1,B);
    cy(1,0,0,0,1,            1,B, 1,B+4);
    cy(1,0,1,B+32'h300,1,    1,B, 1,B+4);
    cy(0,0,0,0,1,            0,0, 1,B+32'h300);
    cy(0,0,0,0,1,            0,0, 1,B+32'h300);
    cy(0,0,0,0,1, 1,B+32'h300,    1,B+32'h304);
    // Redirect from IDLE to the top of memory: PC wraps, pop+push at count 1.
    rr(1);
    cy(0,0,1,32'hFFFFFFFC,1, 0,0,            0,0);
    cy(0,0,0,0,1,            0,0,            1,32'hFFFFFFFC);
    cy(0,0,0,0,1,            0,0,            1,32'hFFFFFFFC);
    cy(1,0,0,0,1,            1,32'hFFFFFFFC, 1,32'h0);
    cy(0,0,0,0,1,            1,32'hFFFFFFFC, 1,32'h0);
    cy(0,0,0,0,1,            1,32'h0,        1,32'h4);
    cy(0,0,0,0,1,            0,0,            1,32'h4);
    cy(0,0,0,0,1,            1,32'h4,        1,32'h8);
    // Reset while a request is outstanding.
    rr(1);
    cy(0,0,0,0,1,  0,0,   0,0);
    add(1, 1, 0, 0, 0, 32'h0, 1, 0, 32'h0, 1, B);
    cy(0,0,0,0,1,  0,0,   0,0);
    cy(0,0,0,0,1,  0,0,   1,B);
    cy(0,0,0,0,1,  0,0,   1,B);
    cy(0,0,0,0,1,  1,B,   1,B+4);

    foreach (tv[i]) begin
      @(negedge clk);
      if (tv[i].chk) begin
        check(i, "rmask", {28'h0, imem_rmask}, tv[i].erm ? 32'hF : 32'h0);
        if (tv[i].erm) check(i, "addr", imem_addr, tv[i].eaddr);
        check(i, "valid", {31'h0, if_id.valid}, {31'h0, tv[i].ev});
        check(i, "resp_id", {31'h0, imem_resp_id}, {31'h0, tv[i].ev});
        if (tv[i].ev) begin
          check(i, "pc", if_id.pc, tv[i].epc);
          check(i, "inst", imem_rdata_id, ~tv[i].epc);
        end
      end
      rst            = tv[i].rst;
      stall_signal   = tv[i].stall;
      freeze_stall   = tv[i].frz;
      flush_pipeline = tv[i].flush;
      redirect_pc    = tv[i].redir;
      mem_lat        = tv[i].lat;
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
